weight_bank_loader: RTL
=======================

// Module: weight_bank_loader
// PURPOSE
//  Writer side of the banked weight store: accepts a serial word stream and assembles NUM-word rows.
//  Writes each row into all NUM weight banks at one shared address, replacing $readmemb preload.
//  Sits between the host/DMA weight stream and the banked RAMs read by the layer engines.
//  Row layout matches the readers: word k of a row is bank k's value, lane k of wr_row.
// PARAMETERS
//  WIDTH  16       bits per weight word
//  ADDR   11       bank address width
//  NUM    64       number of banks = words per row
//  DEPTH  2**ADDR  rows per load (1..2**ADDR); rows written at addresses 0..DEPTH-1
// PORTS
//  clk       in   1            clock; all state on posedge
//  rst       in   1            asynchronous, active-high reset
//  start     in   1            one-cycle pulse; begins a load (honoured only in IDLE or DONE)
//  in_valid  in   1            in_data valid
//  in_data   in   WIDTH        next weight word, bank order 0..NUM-1, then next address
//  in_ready  out  1            loader accepts a word; transfer = in_valid & in_ready
//  wr_en     out  1            one-cycle row write strobe to all banks
//  wr_addr   out  ADDR         row address for wr_en
//  wr_row    out  WIDTH x NUM  unpacked [0:NUM-1]; lane k goes to bank k
//  busy      out  1            high in LOAD state
//  done      out  1            high in DONE state (level, cleared by next start)
// BEHAVIOUR
//  Reset (async): state=IDLE, word index=0, row count=0.
//  Reset (async): in_ready=0, wr_en=0, wr_addr=0, wr_row all 0, busy=0, done=0.
//  FSM IDLE -start-> LOAD; LOAD -last word of row DEPTH-1 accepted-> DONE; DONE -start-> LOAD.
//  in_ready = (state==LOAD), combinational from state only; never depends on in_valid.
//  LOAD: each transfer stores in_data into lane idx of the row buffer, then idx increments.
//  On the transfer at idx==NUM-1:
//   - next cycle: wr_en=1, wr_addr=row count, wr_row=buffer with the final word included.
//   - idx wraps to 0 and row count increments.
//  Latency: exactly 1 cycle from the last-word accept to wr_en.
//  wr_row/wr_addr hold their value until the next row write.
//  No bubble: a word accepted in the wr_en cycle goes to lane 0 of the next row (buffer copied, not shared).
//  Final row (row count==DEPTH-1, idx==NUM-1): that cycle moves to DONE and in_ready drops.
//  The wr_en of the final row appears in the first DONE cycle; done rises in that same cycle.
//  start in LOAD is ignored; start in DONE clears done, resets idx and row count, enters LOAD.
//  in_valid while not LOAD is ignored; no word is consumed.
//  Mid-load reset aborts; partial row discarded; no wr_en is issued for it.
//  Counters: idx width $clog2(NUM), row count width ADDR+1 so DEPTH=2**ADDR does not overflow.
//  wr_addr = row count[ADDR-1:0].
// STRUCTURE
//  Shared package weight_pkg:
//   - WIDTH/ADDR/NUM defaults.
//   - typedef word_t = logic [WIDTH-1:0].
//   - typedef enum {IDLE, LOAD, DONE} ld_state_t.
//  Sub-module row_assembler: idx counter, row buffer, row_full pulse, copy to wr_row register.
//  Top holds the FSM, row counter and wr_en/wr_addr/busy/done.
// TESTING (bench with NUM=4, DEPTH=3, WIDTH=16, ADDR=2 unless stated)
//  Reset then idle, start=0, in_valid=1 for 10 cycles:
//   -> in_ready=0, wr_en=0, outputs all 0, busy=0, done=0.
//  start, stream 0x0001..0x000C with continuous valid:
//   -> wr_en at addr 0,1,2 with rows {1,2,3,4},{5,6,7,8},{9,A,B,C}.
//   -> each wr_en 1 cycle after words 4, 8, 12; done high with the third wr_en; busy low.
//  Same stream with random in_valid gaps:
//   -> identical rows/addresses; exactly 3 wr_en pulses; no word lost or duplicated.
//  start pulses during LOAD after word 2:
//   -> ignored; rows unchanged.
//  start in DONE, stream 0x0100..0x010B:
//   -> done clears next cycle; rows rewritten at addr 0..2 with new data.
//  rst asserted asynchronously after 6 words:
//   -> all outputs 0 immediately; restart writes row 0 from the first new word.
//  No wr_en for the aborted partial row.
//  Default params NUM=64, DEPTH=2048:
//   -> 131072 words give 2048 wr_en pulses; wr_addr 0..2047 monotonic; done asserted once.

Source files
------------

// File: rtl/weight_bank_loader_pkg.sv
// Shared types and default sizes for the banked weight store writer.
package weight_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int ADDR_DEF  = 11;
  localparam int NUM_DEF   = 64;

  typedef logic [WIDTH_DEF-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ld_state_t;

endpackage

// File: rtl/weight_bank_loader_if.sv
// Weight stream input plus the row-write bus toward the banks, with status.
interface weight_bank_loader_if
  import weight_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ADDR  = ADDR_DEF,
  parameter int NUM   = NUM_DEF
);

  logic             start;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             wr_en;
  logic [ADDR-1:0]  wr_addr;
  logic [WIDTH-1:0] wr_row [NUM];
  logic             busy;
  logic             done;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_row, busy, done
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_row, busy, done
  );

endinterface

// File: rtl/weight_bank_loader_row_assembler.sv
// Collects NUM words into a row buffer and snapshots the completed row
// (including the word arriving on the closing transfer) into wr_row.
module row_assembler #(
  parameter int WIDTH = 16,
  parameter int NUM   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             row_full_o,
  output logic [WIDTH-1:0] wr_row_o [NUM]
);

  localparam int            IW       = $clog2(NUM);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM - 1);

  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] buf_q    [NUM];
  logic [WIDTH-1:0] row_d    [NUM];
  logic [WIDTH-1:0] wr_row_q [NUM];

  assign row_full_o = push_i & (idx_q == IDX_LAST);
  assign wr_row_o   = wr_row_q;

  // Completed row: buffered lanes plus the last word still on the input.
  always_comb begin
    for (int k = 0; k < NUM; k++) begin
      if (k == NUM - 1) begin
        row_d[k] = data_i;
      end else begin
        row_d[k] = buf_q[k];
      end
    end
  end

  // Word index, row buffer and the separate output copy so the next row can
  // start filling in the same cycle wr_en is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      for (int k = 0; k < NUM; k++) begin
        buf_q[k]    <= '0;
        wr_row_q[k] <= '0;
      end
    end else begin
      if (clr_i) begin
        idx_q <= '0;
      end else if (push_i) begin
        buf_q[idx_q] <= data_i;
        idx_q        <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end
      if (row_full_o) begin
        wr_row_q <= row_d;
      end
    end
  end

endmodule

// File: rtl/weight_bank_loader.sv
// Loads DEPTH rows of NUM serial weight words into all banks at shared
// addresses 0..DEPTH-1; holds the load FSM, row counter and write strobe.
module weight_bank_loader
  import weight_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ADDR  = ADDR_DEF,
  parameter int NUM   = NUM_DEF,
  parameter int DEPTH = 2 ** ADDR
) (
  input logic                clk,
  input logic                rst,
  weight_bank_loader_if.slave ld_if
);

  // Row counter is one bit wider so DEPTH == 2**ADDR fits.
  localparam logic [ADDR:0] ROW_LAST = (ADDR + 1)'(DEPTH - 1);

  ld_state_t        state_q;
  logic [ADDR:0]    rows_q;
  logic             wr_en_q;
  logic [ADDR-1:0]  wr_addr_q;
  logic             load_s;
  logic             xfer_s;
  logic             go_s;
  logic             row_full_s;
  logic [WIDTH-1:0] wr_row_s [NUM];

  assign load_s = (state_q == LOAD);
  assign xfer_s = ld_if.in_valid & load_s;
  assign go_s   = ld_if.start & ~load_s;

  assign ld_if.in_ready = load_s;
  assign ld_if.busy     = load_s;
  assign ld_if.done     = (state_q == DONE);
  assign ld_if.wr_en    = wr_en_q;
  assign ld_if.wr_addr  = wr_addr_q;
  assign ld_if.wr_row   = wr_row_s;

  row_assembler #(
    .WIDTH (WIDTH),
    .NUM   (NUM)
  ) u_row_assembler (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (go_s),
    .push_i     (xfer_s),
    .data_i     (ld_if.in_data),
    .row_full_o (row_full_s),
    .wr_row_o   (wr_row_s)
  );

  // Load FSM with row counter and the one-cycle-delayed row write strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rows_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      wr_en_q <= row_full_s;
      if (row_full_s) begin
        wr_addr_q <= rows_q[ADDR-1:0];
      end
      case (state_q)
        IDLE, DONE: begin
          if (ld_if.start) begin
            state_q <= LOAD;
            rows_q  <= '0;
          end
        end
        LOAD: begin
          if (row_full_s) begin
            rows_q <= rows_q + (ADDR + 1)'(1);
            if (rows_q == ROW_LAST) begin
              state_q <= DONE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          rows_q  <= '0;
        end
      endcase
    end
  end

endmodule
